// File: rtl/l2k_alu_arb.sv
// Two-requester front end for a shared l2k_alu: arbitration, one-deep result
// register with valid/ready handshake, and saturating per-requester grant counters.

module l2k_alu (
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result
);

  typedef enum logic [2:0] {
    OP_ILL  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_SLTS = 3'b100,
    OP_SLT  = 3'b101,
    OP_SUB  = 3'b110,
    OP_ADD  = 3'b111
  } alu_op_e;

  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_op))
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_SLT:  o_result = {31'b0, (i_a < i_b)};
      OP_SLTS: o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

module l2k_alu_arb #(
  parameter bit          RR_EN = 1'b1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [31:0]      r0_a,
  input  logic [31:0]      r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [31:0]      r1_a,
  input  logic [31:0]      r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_illegal;
  logic             r_ptr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic [2:0]       w_op;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [31:0]      w_alu_result;
  logic             w_illegal;

  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // With both valid, requester 0 wins under fixed priority or when the pointer favours it.
  assign w_gnt0 = r0_valid && (!r1_valid || !RR_EN || !r_ptr);
  assign w_gnt1 = r1_valid && !w_gnt0;

  assign w_acc0 = w_gnt0 && w_can_accept;
  assign w_acc1 = w_gnt1 && w_can_accept;
  assign w_acc  = w_acc0 || w_acc1;

  assign r0_ready = w_acc0;
  assign r1_ready = w_acc1;

  always_comb begin
    w_op = r0_op;
    w_a  = r0_a;
    w_b  = r0_b;
    if (w_gnt1) begin
      w_op = r1_op;
      w_a  = r1_a;
      w_b  = r1_b;
    end
  end

  assign w_illegal = (w_op == 3'b000);

  l2k_alu u_alu (
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_result (w_alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_illegal <= 1'b0;
      r_ptr         <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_id      <= w_acc1;
        r_rsp_data    <= w_illegal ? '0 : w_alu_result;
        r_rsp_illegal <= w_illegal;
        if (RR_EN) begin
          r_ptr <= w_acc0;
        end
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_acc1 && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_illegal = r_rsp_illegal;
  assign gnt_cnt0    = r_cnt0;
  assign gnt_cnt1    = r_cnt1;

endmodule

// File: tb/tb_l2k_alu_arb.sv
// Directed bench for l2k_alu_arb: a round-robin instance and a fixed-priority
// instance, each with an expected-response queue drained by its own monitor.

module tb_l2k_alu_arb;

  localparam logic [2:0] OP_ILL  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLTS = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ADD  = 3'b111;

  typedef struct packed {
    logic        id;
    logic        ill;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rsp_ready;
  logic        r0_valid, r1_valid;
  logic [2:0]  r0_op, r1_op;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_ready, r1_ready;
  logic        rsp_valid, rsp_id, rsp_illegal;
  logic [31:0] rsp_data;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  logic        f_r0_valid, f_r1_valid;
  logic        f_r0_ready, f_r1_ready;
  logic        f_rsp_valid, f_rsp_id, f_rsp_illegal;
  logic [31:0] f_rsp_data;
  logic [15:0] f_gnt_cnt0, f_gnt_cnt1;

  exp_t q_rr[$];
  exp_t q_fp[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   last_wait;

  always #5 clk = ~clk;

  l2k_alu_arb #(.RR_EN(1'b1), .CNT_W(16)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  l2k_alu_arb #(.RR_EN(1'b0), .CNT_W(16)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(f_r0_valid), .r0_ready(f_r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(f_r1_valid), .r1_ready(f_r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
    .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data),
    .rsp_illegal(f_rsp_illegal), .gnt_cnt0(f_gnt_cnt0), .gnt_cnt1(f_gnt_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a response is handed over.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q_rr.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rr_unexpected_rsp @%0t: got id=%0d data=%h, expected none", $time, rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q_rr.pop_front();
        chk("rr_rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
        chk("rr_rsp_data", rsp_data, e.data);
        chk("rr_rsp_illegal", {31'b0, rsp_illegal}, {31'b0, e.ill});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_rsp_valid && rsp_ready) begin
      if (q_fp.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fp_unexpected_rsp @%0t: got id=%0d data=%h, expected none", $time, f_rsp_id, f_rsp_data);
      end else begin
        exp_t e;
        e = q_fp.pop_front();
        chk("fp_rsp_id", {31'b0, f_rsp_id}, {31'b0, e.id});
        chk("fp_rsp_data", f_rsp_data, e.data);
        chk("fp_rsp_illegal", {31'b0, f_rsp_illegal}, {31'b0, e.ill});
      end
    end
  end

  // Requester obligation: operands stay put while a request is stalled.
  logic        p0 = 1'b0, p1 = 1'b0;
  logic [66:0] s0, s1;
  always @(negedge clk) begin
    if (rst_n && p0) assert ({r0_op, r0_a, r0_b} == s0) else $error("r0 operands changed while stalled");
    if (rst_n && p1) assert ({r1_op, r1_a, r1_b} == s1) else $error("r1 operands changed while stalled");
    p0 = r0_valid && !r0_ready;
    p1 = r1_valid && !r1_ready;
    s0 = {r0_op, r0_a, r0_b};
    s1 = {r1_op, r1_a, r1_b};
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic ei, input bit push);
    bit ok;
    if (push) q_rr.push_back('{id: id, ill: ei, data: ed});
    if (id) begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    ok = 1'b0;
    last_wait = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? r1_ready : r0_ready) begin
        ok = 1'b1;
        break;
      end
      last_wait++;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout @%0t: requester %0d got no ready, expected ready within 20 cycles", $time, id);
    end
    @(posedge clk);
    #1;
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog @%0t: bench did not finish, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    r0_valid = 1'b0; r1_valid = 1'b0; f_r0_valid = 1'b0; f_r1_valid = 1'b0;
    r0_op = OP_ADD; r1_op = OP_ADD; r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("reset_rsp_illegal", {31'b0, rsp_illegal}, 32'd0);
    chk("reset_cnt0", {16'b0, gnt_cnt0}, 32'd0);
    chk("reset_cnt1", {16'b0, gnt_cnt1}, 32'd0);
    chk("reset_fp_valid", {31'b0, f_rsp_valid}, 32'd0);
    idle(1);

    // ADD with single-cycle acceptance and result visible the next cycle
    send(1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
    chk("add_ready_latency", last_wait, 32'd0);
    @(negedge clk);
    chk("add_rsp_valid_next", {31'b0, rsp_valid}, 32'd1);
    chk("add_rsp_data_next", rsp_data, 32'd12);
    idle(1);

    send(1'b1, OP_SLTS, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1);
    send(1'b1, OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    send(1'b1, OP_SUB,  32'd0,         32'd1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("consume_drops_valid", {31'b0, rsp_valid}, 32'd0);
    chk("consume_holds_data", rsp_data, 32'hFFFF_FFFF);
    chk("consume_holds_id", {31'b0, rsp_id}, 32'd1);
    idle(1);

    // Both requesters continuously valid for six grants, both arbitration modes
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q_rr.push_back('{id: 1'(i % 2), ill: 1'b0, data: (i % 2) ? 32'd9 : 32'd11});
      q_fp.push_back('{id: 1'b0, ill: 1'b0, data: 32'd11});
    end
    r0_op = OP_ADD; r0_a = 32'd10; r0_b = 32'd1;
    r1_op = OP_SUB; r1_a = 32'd10; r1_b = 32'd1;
    r0_valid = 1'b1; r1_valid = 1'b1; f_r0_valid = 1'b1; f_r1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fp_r0_ready", {31'b0, f_r0_ready}, 32'd1);
      chk("fp_r1_ready", {31'b0, f_r1_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    r0_valid = 1'b0; r1_valid = 1'b0; f_r0_valid = 1'b0; f_r1_valid = 1'b0;
    @(negedge clk);
    chk("rr_gnt_cnt0", {16'b0, gnt_cnt0}, 32'd3);
    chk("rr_gnt_cnt1", {16'b0, gnt_cnt1}, 32'd3);
    chk("fp_gnt_cnt0", {16'b0, f_gnt_cnt0}, 32'd6);
    chk("fp_gnt_cnt1", {16'b0, f_gnt_cnt1}, 32'd0);
    idle(1);

    // Backpressure: XOR result held for four cycles, then queued ops issue with no bubble
    rsp_ready = 1'b0;
    send(1'b0, OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1);
    q_rr.push_back('{id: 1'b1, ill: 1'b0, data: 32'h0000_00FF});
    q_rr.push_back('{id: 1'b0, ill: 1'b0, data: 32'd5});
    r0_op = OP_ADD; r0_a = 32'd2;  r0_b = 32'd3;  r0_valid = 1'b1;
    r1_op = OP_OR;  r1_a = 32'h0F; r1_b = 32'hF0; r1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_r0_ready", {31'b0, r0_ready}, 32'd0);
      chk("stall_r1_ready", {31'b0, r1_ready}, 32'd0);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_data", rsp_data, 32'h0FF0_0FF0);
      chk("stall_rsp_id", {31'b0, rsp_id}, 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_r1_ready", {31'b0, r1_ready}, 32'd1);
    chk("release_r0_ready", {31'b0, r0_ready}, 32'd0);
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    @(negedge clk);
    chk("nobubble_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("nobubble_r0_ready", {31'b0, r0_ready}, 32'd1);
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    idle(2);

    send(1'b0, OP_ILL, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1);
    send(1'b0, OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
    idle(3);

    // Reset while a result is stalled: discarded, then arbitration restarts at requester 0
    rsp_ready = 1'b0;
    send(1'b1, OP_SUB, 32'd20, 32'd5, 32'd15, 1'b0, 1'b0);
    @(negedge clk);
    chk("prereset_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("prereset_rsp_data", rsp_data, 32'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midreset_rsp_data", rsp_data, 32'd0);
    chk("midreset_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("midreset_cnt1", {16'b0, gnt_cnt1}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    q_rr.push_back('{id: 1'b0, ill: 1'b0, data: 32'd2});
    q_rr.push_back('{id: 1'b1, ill: 1'b0, data: 32'd6});
    r0_op = OP_ADD; r0_a = 32'd1; r0_b = 32'd1; r0_valid = 1'b1;
    r1_op = OP_ADD; r1_a = 32'd3; r1_b = 32'd3; r1_valid = 1'b1;
    @(negedge clk);
    chk("postreset_r0_ready", {31'b0, r0_ready}, 32'd1);
    chk("postreset_r1_ready", {31'b0, r1_ready}, 32'd0);
    @(posedge clk);
    #1;
    r0_valid = 1'b0;
    @(negedge clk);
    chk("postreset_r1_next", {31'b0, r1_ready}, 32'd1);
    @(posedge clk);
    #1;
    r1_valid = 1'b0;
    idle(3);

    chk("rr_queue_drained", q_rr.size(), 32'd0);
    chk("fp_queue_drained", q_fp.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2k_alu_arb.md
Name: l2k_alu_arb

Overview:
- Shares one `l2k_alu` instance between two requesters in the Limn2600 core.
  - Requester 0: integer execute path.
  - Requester 1: address/compare helper path.
- Arbitrates with round-robin or fixed priority, drives the ALU from the granted requester, registers the result, and returns it on one response channel with backpressure.
- At most one result is held. Throughput is one operation per cycle while the response side accepts.

Parameters:
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
- CNT_W, 16, width of the per-requester grant counters; counters saturate at all-ones.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- r0_valid  input  1  requester 0 has an operation.
- r0_ready  output  1  requester 0 operation accepted this cycle.
- r0_op  input  3  ALU opcode: 111 ADD, 110 SUB, 011 AND, 010 XOR, 001 OR, 101 SLT, 100 SLTS, 000 illegal.
- r0_a  input  32  operand A.
- r0_b  input  32  operand B.
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same widths and meaning, requester 1.
- rsp_valid  output  1  result held.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  requester index that owns the result.
- rsp_data  output  32  ALU result.
- rsp_illegal  output  1  opcode was 000.
- gnt_cnt0  output  CNT_W  saturating count of grants to requester 0.
- gnt_cnt1  output  CNT_W  saturating count of grants to requester 1.

Behaviour:
- Reset (async assert, sync deassert by the system): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_illegal=0, gnt_cnt0=gnt_cnt1=0, RR pointer=0 (requester 0 preferred).
- can_accept = !rsp_valid || rsp_ready. Holding a result while rsp_ready=0 blocks all grants.
- Grant:
  - Only one requester valid: that one wins.
  - Both valid, RR_EN=1: the pointer's requester wins.
  - Both valid, RR_EN=0: requester 0 wins.
  - rN_ready = grantN && can_accept. It is combinational and never depends on rsp_data.
- Pointer update: on every accepted grant with RR_EN=1, pointer = index of the other requester. With no grant the pointer holds.
- ALU inputs are muxed combinationally from the granted requester. When no grant is active, op/a/b are driven from requester 0 and the result is ignored.
- Latency: accept on edge N -> rsp_valid=1 with result after edge N; visible in cycle N+1.
- Back-to-back: a grant and a consume (rsp_valid && rsp_ready) in the same cycle overwrites the result register. rsp_valid stays 1 and no bubble is inserted.
- Consume without a new grant: rsp_valid -> 0 next cycle. rsp_data, rsp_id and rsp_illegal hold their last value.
- Response stability: while rsp_valid && !rsp_ready, rsp_data, rsp_id and rsp_illegal are stable.
- Requester obligations: op/a/b are stable while valid && !ready. The bench flags violations with an assertion; the block does not check them.
- Illegal opcode 000: accepted normally. rsp_data=0 (explicit, not taken from the ALU default branch), rsp_illegal=1.
- Arithmetic:
  - ADD/SUB wrap modulo 2^32; there is no carry or overflow output.
  - SLT is unsigned.
  - SLTS is signed.
  - Both return 0 or 1 in bit 0 with bits 31:1 = 0.
- Grant counters increment on accepted grants only and saturate at 2^CNT_W-1. They are not cleared except by reset.
- Reset mid-operation: a pending result is discarded and no response is issued for it. Requesters must re-issue.

Test Plan:
- r0: ADD a=5 b=7, rsp_ready=1 -> r0_ready=1 in cycle 0; rsp_valid=1, rsp_data=12, rsp_id=0 in cycle 1.
- r1: SLTS a=0xFFFFFFFF b=1 -> rsp_data=1. Repeat as SLT -> rsp_data=0. SUB a=0 b=1 -> 0xFFFFFFFF.
- Both requesters valid continuously for 6 cycles, RR_EN=1, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1; gnt_cnt0=gnt_cnt1=3. Same with RR_EN=0 -> all six grants go to requester 0.
- rsp_ready=0 for 4 cycles after the first result (r0 XOR 0xF0F0F0F0 ^ 0xFF00FF00) -> rsp_data=0x0FF00FF0 held stable, both rN_ready=0. Release -> next pending op issues on the same edge with no bubble.
- r0_op=000 a=3 b=4 -> rsp_data=0, rsp_illegal=1. The following ADD 1+1 -> rsp_data=2, rsp_illegal=0.
- rst_n asserted while rsp_valid=1 and rsp_ready=0 -> outputs clear immediately. After release, the first grant goes to requester 0 when both are valid.
